// File: rtl/fx_ctrl_pkg.sv
// fx_ctrl_pkg
// Shared types and constants for the effects-chain pedal-board controller:
//   - ramp_state_t : per-effect wet/dry ramp states
//   - sel_state_t  : armed-effect selection filter states
//   - SEL_* codes  : committed selection values (0 = none, 1..4 = effect 0..3)
//   - POT_* codes  : slider pot_0 top-nibble patterns that select each effect
//   - pot_decode() : maps sel_pot[11:8] to a selection code
package fx_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    RAMP_UP = 2'd1,
    ON      = 2'd2,
    RAMP_DN = 2'd3
  } ramp_state_t;

  typedef enum logic {
    SEL_STABLE  = 1'b0,
    SEL_PENDING = 1'b1
  } sel_state_t;

  localparam logic [2:0] SEL_NONE    = 3'd0;
  localparam logic [2:0] SEL_FLANGER = 3'd1;
  localparam logic [2:0] SEL_CHORUS  = 3'd2;
  localparam logic [2:0] SEL_DELAY   = 3'd3;
  localparam logic [2:0] SEL_REVERB  = 3'd4;

  localparam logic [3:0] POT_FLANGER = 4'b0001;
  localparam logic [3:0] POT_CHORUS  = 4'b0011;
  localparam logic [3:0] POT_DELAY   = 4'b0111;
  localparam logic [3:0] POT_REVERB  = 4'b1111;

  // Thermometer-style slider positions; anything in between reads as "none".
  function automatic logic [2:0] pot_decode(input logic [3:0] pot_hi);
    logic [2:0] code;
    case (pot_hi)
      POT_REVERB:  code = SEL_REVERB;
      POT_DELAY:   code = SEL_DELAY;
      POT_CHORUS:  code = SEL_CHORUS;
      POT_FLANGER: code = SEL_FLANGER;
      default:     code = SEL_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fx_ramp.sv
// fx_ramp
// One effect's click-free wet/dry ramp: a four-state FSM plus a saturating
// mix register that moves by RAMP_STEP on each valid strobe.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset (aborts any ramp, mix -> 0)
//   valid   in  codec sample strobe; the mix only moves on these
//   on      in  target enable for this effect
//   mix     out current mix coefficient (all ones = fully wet)
//   ramping out high while the mix is moving (RAMP_UP or RAMP_DN)
module fx_ramp
  import fx_ctrl_pkg::*;
#(
  parameter int MIX_W     = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             on,
  output logic [MIX_W-1:0] mix,
  output logic             ramping
);

  localparam logic [MIX_W-1:0] MIX_MAX  = {MIX_W{1'b1}};
  localparam logic [MIX_W:0]   MAX_EXT  = {1'b0, {MIX_W{1'b1}}};
  localparam logic [MIX_W:0]   STEP_EXT = (MIX_W+1)'(RAMP_STEP);
  localparam logic [MIX_W-1:0] STEP_N   = MIX_W'(RAMP_STEP);

  ramp_state_t      state;
  ramp_state_t      state_next;
  logic [MIX_W-1:0] mix_next;
  logic             ramping_next;
  logic [MIX_W:0]   up_sum;

  // Next-state and mix arithmetic. A valid that coincides with a direction
  // change still steps in the old direction; the reversal is taken from the
  // current mix value, so there is never a jump.
  always_comb begin
    state_next = state;
    mix_next   = mix;
    up_sum     = {1'b0, mix} + STEP_EXT;
    case (state)
      OFF: begin
        mix_next = '0;
        if (on) begin
          state_next = RAMP_UP;
        end else begin
          state_next = OFF;
        end
      end
      RAMP_UP: begin
        if (valid && (up_sum >= MAX_EXT)) begin
          mix_next   = MIX_MAX;
          state_next = ON;
        end else begin
          if (valid) begin
            mix_next = up_sum[MIX_W-1:0];
          end else begin
            mix_next = mix;
          end
          state_next = on ? RAMP_UP : RAMP_DN;
        end
      end
      ON: begin
        mix_next   = MIX_MAX;
        state_next = on ? ON : RAMP_DN;
      end
      RAMP_DN: begin
        if (valid && ({1'b0, mix} <= STEP_EXT)) begin
          mix_next   = '0;
          state_next = OFF;
        end else begin
          if (valid) begin
            mix_next = mix - STEP_N;
          end else begin
            mix_next = mix;
          end
          state_next = on ? RAMP_UP : RAMP_DN;
        end
      end
      default: begin
        mix_next   = '0;
        state_next = OFF;
      end
    endcase
    ramping_next = (state_next == RAMP_UP) || (state_next == RAMP_DN);
  end

  // State, mix and ramping flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= OFF;
      mix     <= '0;
      ramping <= 1'b0;
    end else begin
      state   <= state_next;
      mix     <= mix_next;
      ramping <= ramping_next;
    end
  end

endmodule

// File: rtl/fx_chain_ctrl.sv
// fx_chain_ctrl
// Pedal-board controller for the flanger -> chorus -> delay -> reverb chain.
// Owns armed-effect selection (pot_0 with dwell filter), push-button enable
// toggling, per-effect wet/dry ramps and the LED pattern.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   valid    in  one-cycle codec sample strobe
//   sel_pot  in  slider pot_0 (only [11:8] used)
//   pb_fall  in  one-cycle debounced push-button press
//   cur_sel  out committed selection, 0 = none, 1..4 = effect 0..3
//   fx_on    out target enable per effect
//   fx_mix   out flattened mix, effect k at [k*MIX_W +: MIX_W]
//   ramping  out effect k mix currently moving
//   led      out LED[2k+1] = effect k selected, LED[2k] = fx_on[k]
// Optional: define FX_BLINK_EN to blink LED[2k] while effect k ramps.
module fx_chain_ctrl
  import fx_ctrl_pkg::*;
#(
  parameter int NUM_FX    = 4,
  parameter int MIX_W     = 8,
  parameter int RAMP_STEP = 4,
  parameter int DWELL     = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [11:0]             sel_pot,
  input  logic                    pb_fall,
  output logic [2:0]              cur_sel,
  output logic [NUM_FX-1:0]       fx_on,
  output logic [NUM_FX*MIX_W-1:0] fx_mix,
  output logic [NUM_FX-1:0]       ramping,
  output logic [7:0]              led
);

  localparam int DWELL_W = $clog2(DWELL + 1);

  sel_state_t          sel_state;
  sel_state_t          sel_state_next;
  logic [2:0]          cand;
  logic [2:0]          cand_next;
  logic [DWELL_W-1:0]  dwell;
  logic [DWELL_W-1:0]  dwell_next;
  logic [2:0]          cur_sel_next;
  logic [2:0]          pot_code;
  logic [NUM_FX-1:0]   fx_on_next;
  logic [7:0]          led_next;

  // Low pot bits carry no information for selection.
  logic                unused_pot_bits;
  assign unused_pot_bits = ^sel_pot[7:0];

  // Selection filter: a new decode must hold for DWELL valid strobes
  // before it commits; returning to the committed code abandons it.
  always_comb begin
    sel_state_next = sel_state;
    cand_next      = cand;
    dwell_next     = dwell;
    cur_sel_next   = cur_sel;
    pot_code       = pot_decode(sel_pot[11:8]);
    case (sel_state)
      SEL_STABLE: begin
        if (valid && (pot_code != cur_sel)) begin
          cand_next = pot_code;
          if (DWELL <= 1) begin
            cur_sel_next = pot_code;
            dwell_next   = '0;
          end else begin
            dwell_next     = DWELL_W'(1);
            sel_state_next = SEL_PENDING;
          end
        end else begin
          sel_state_next = SEL_STABLE;
        end
      end
      SEL_PENDING: begin
        if (valid) begin
          if (pot_code == cand) begin
            if ((dwell + DWELL_W'(1)) >= DWELL_W'(DWELL)) begin
              cur_sel_next   = cand;
              dwell_next     = '0;
              sel_state_next = SEL_STABLE;
            end else begin
              dwell_next = dwell + DWELL_W'(1);
            end
          end else if (pot_code == cur_sel) begin
            dwell_next     = '0;
            sel_state_next = SEL_STABLE;
          end else begin
            cand_next  = pot_code;
            dwell_next = DWELL_W'(1);
          end
        end else begin
          sel_state_next = SEL_PENDING;
        end
      end
      default: begin
        dwell_next     = '0;
        sel_state_next = SEL_STABLE;
      end
    endcase
  end

  // Enable toggling acts on the selection registered before this edge,
  // so a press in the commit cycle still hits the previously armed effect.
  always_comb begin
    fx_on_next = fx_on;
    for (int k = 0; k < NUM_FX; k++) begin
      if (pb_fall && (cur_sel == 3'(k + 1))) begin
        fx_on_next[k] = ~fx_on[k];
      end else begin
        fx_on_next[k] = fx_on[k];
      end
    end
  end

`ifdef FX_BLINK_EN
  logic [3:0] blink_cnt;
  logic       blink_phase;

  // Shared valid counter; the blink phase flips every 16 strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= 4'd0;
      blink_phase <= 1'b0;
    end else if (valid) begin
      blink_cnt <= blink_cnt + 4'd1;
      if (blink_cnt == 4'd15) begin
        blink_phase <= ~blink_phase;
      end else begin
        blink_phase <= blink_phase;
      end
    end else begin
      blink_cnt   <= blink_cnt;
      blink_phase <= blink_phase;
    end
  end
`endif

  // LED pattern built from the next-state values so it updates on the
  // same edge as cur_sel / fx_on.
  always_comb begin
    led_next = 8'h00;
    for (int k = 0; k < NUM_FX; k++) begin
      led_next[2*k+1] = (cur_sel_next == 3'(k + 1));
`ifdef FX_BLINK_EN
      if (ramping[k]) begin
        led_next[2*k] = fx_on_next[k] ^ blink_phase;
      end else begin
        led_next[2*k] = fx_on_next[k];
      end
`else
      led_next[2*k] = fx_on_next[k];
`endif
    end
  end

  // Selection, enable and LED registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_state <= SEL_STABLE;
      cand      <= SEL_NONE;
      dwell     <= '0;
      cur_sel   <= SEL_NONE;
      fx_on     <= '0;
      led       <= 8'h00;
    end else begin
      sel_state <= sel_state_next;
      cand      <= cand_next;
      dwell     <= dwell_next;
      cur_sel   <= cur_sel_next;
      fx_on     <= fx_on_next;
      led       <= led_next;
    end
  end

  for (genvar k = 0; k < NUM_FX; k++) begin : g_ramp
    fx_ramp #(
      .MIX_W     (MIX_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid),
      .on      (fx_on[k]),
      .mix     (fx_mix[k*MIX_W +: MIX_W]),
      .ramping (ramping[k])
    );
  end

endmodule

// File: tb/tb_fx_chain_ctrl.sv
module tb_fx_chain_ctrl;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [11:0] sel_pot;
  logic        pb_fall;
  logic [2:0]  cur_sel;
  logic [3:0]  fx_on;
  logic [31:0] fx_mix;
  logic [3:0]  ramping;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model state: plain integers per the behavioural rules
  int m_cur, m_cand, m_cnt;
  bit m_pend;
  bit m_on  [4];
  int m_mix [4];
  int m_dir [4];   // +1 rising, -1 falling, 0 settled

  fx_chain_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .sel_pot (sel_pot),
    .pb_fall (pb_fall),
    .cur_sel (cur_sel),
    .fx_on   (fx_on),
    .fx_mix  (fx_mix),
    .ramping (ramping),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic int dec(input logic [3:0] p);
    case (p)
      4'hF:    return 4;
      4'h7:    return 3;
      4'h3:    return 2;
      4'h1:    return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int  old_cur;
    int  d;
    bit  settled;
    if (rst) begin
      m_cur = 0; m_pend = 0; m_cand = 0; m_cnt = 0;
      for (int k = 0; k < 4; k++) begin
        m_on[k] = 0; m_mix[k] = 0; m_dir[k] = 0;
      end
    end else begin
      old_cur = m_cur;
      // ramps use the enable as it stood before this edge
      for (int k = 0; k < 4; k++) begin
        settled = 0;
        if (valid && m_dir[k] != 0) begin
          m_mix[k] = m_mix[k] + m_dir[k] * 4;
          if (m_mix[k] >= 255) begin
            m_mix[k] = 255; m_dir[k] = 0; settled = 1;
          end else if (m_mix[k] <= 0) begin
            m_mix[k] = 0; m_dir[k] = 0; settled = 1;
          end
        end
        if (!settled && (m_dir[k] != 0 || m_mix[k] != (m_on[k] ? 255 : 0)))
          m_dir[k] = m_on[k] ? 1 : -1;
      end
      if (valid) begin
        d = dec(sel_pot[11:8]);
        if (!m_pend) begin
          if (d != m_cur) begin m_pend = 1; m_cand = d; m_cnt = 1; end
        end else if (d == m_cand) begin
          m_cnt++;
        end else if (d == m_cur) begin
          m_pend = 0; m_cnt = 0;
        end else begin
          m_cand = d; m_cnt = 1;
        end
        if (m_pend && m_cnt >= 64) begin
          m_cur = m_cand; m_pend = 0; m_cnt = 0;
        end
      end
      if (pb_fall && old_cur != 0)
        m_on[old_cur-1] = !m_on[old_cur-1];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare against the model, away from the active edge
  initial forever begin
    logic [31:0] e_mix;
    logic [7:0]  e_led;
    logic [3:0]  e_on, e_rmp;
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        e_mix[k*8 +: 8] = 8'(m_mix[k]);
        e_on[k]         = m_on[k];
        e_rmp[k]        = (m_dir[k] != 0);
        e_led[2*k+1]    = (m_cur == k + 1);
        e_led[2*k]      = m_on[k];
      end
      check("cur_sel", 32'(cur_sel), 32'(m_cur));
      check("fx_on",   32'(fx_on),   32'(e_on));
      check("fx_mix",  fx_mix,       e_mix);
      check("ramping", 32'(ramping), 32'(e_rmp));
      check("led",     32'(led),     32'(e_led));
    end
  end

  task automatic cyc(input bit v, input bit pb);
    valid   = v;
    pb_fall = pb;
    @(posedge clk);
    #1;
    valid   = 1'b0;
    pb_fall = 1'b0;
  endtask

  task automatic vstep(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; pb_fall = 1'b0; sel_pot = 12'h000;
    cyc(0, 0); cyc(0, 0);
    rst = 1'b0;
    chk_en = 1;
    check("reset_outs", {cur_sel, fx_on, ramping, led}, 32'h0);
    check("reset_mix", fx_mix, 32'h0);

    // dwell: 63 valids not enough, 64th commits reverb
    sel_pot = 12'hF00;
    vstep(63);
    check("dwell63_sel", 32'(cur_sel), 32'd0);
    vstep(1);
    check("dwell64_sel", 32'(cur_sel), 32'd4);
    check("dwell64_led", 32'(led), 32'h80);

    // select flanger, toggle on, full ramp
    sel_pot = 12'h100;
    vstep(64);
    check("sel_flanger", 32'(cur_sel), 32'd1);
    cyc(0, 1);
    check("toggle_on", 32'(fx_on), 32'h1);
    cyc(0, 0);
    vstep(64);
    check("full_mix", 32'(fx_mix[7:0]), 32'd255);
    check("full_rmp", 32'(ramping[0]), 32'd0);

    // ramp fully down, then up to 100 and reverse mid-ramp
    cyc(0, 1); cyc(0, 0);
    vstep(64);
    check("down_mix", 32'(fx_mix[7:0]), 32'd0);
    cyc(0, 1); cyc(0, 0);
    vstep(25);
    check("mid_mix", 32'(fx_mix[7:0]), 32'd100);
    check("mid_rmp", 32'(ramping[0]), 32'd1);
    cyc(0, 1); cyc(0, 0);
    vstep(25);
    check("rev_mix", 32'(fx_mix[7:0]), 32'd0);
    check("rev_on", 32'(fx_on[0]), 32'd0);
    check("rev_rmp", 32'(ramping[0]), 32'd0);

    // toggle and valid in the same cycle: old direction first
    cyc(0, 1); cyc(0, 0);
    vstep(25);
    cyc(1, 1);
    check("same_cyc_mix", 32'(fx_mix[7:0]), 32'd104);
    cyc(0, 0); cyc(0, 0);
    vstep(1);
    check("after_rev_mix", 32'(fx_mix[7:0]), 32'd100);

    // reset mid-ramp at mix 128
    cyc(0, 1); cyc(0, 0);
    vstep(7);
    check("pre_rst_mix", 32'(fx_mix[7:0]), 32'd128);
    rst = 1'b1;
    cyc(0, 0);
    rst = 1'b0;
    check("rst_outs", {cur_sel, fx_on, ramping, led}, 32'h0);
    check("rst_mix", fx_mix, 32'h0);

    // press with nothing selected is ignored
    cyc(0, 1);
    check("pb_none", 32'(fx_on), 32'h0);

    // alternating pot never holds long enough
    for (int i = 0; i < 10; i++) begin
      sel_pot = (i % 2 == 0) ? 12'h700 : 12'h300;
      vstep(10);
    end
    check("flicker_sel", 32'(cur_sel), 32'd0);

    // randomized run, checked every cycle by the model compare
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 5))
          0:       sel_pot = 12'hF00;
          1:       sel_pot = 12'h700;
          2:       sel_pot = 12'h300;
          3:       sel_pot = 12'h100;
          4:       sel_pot = 12'h000;
          default: sel_pot = 12'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 1999) == 0);
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
    end
    rst = 1'b0;
    cyc(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
